// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: instruction width, FSM state encodings,
// default NOP encoding and PC helpers.
package fetch_stage_pkg;

    localparam int          LEN_INST = 32;
    localparam logic [31:0] NOP_ENC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush has priority over load; hold freezes the contents.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [LEN_INST-1:0] NOP_INST = NOP_ENC
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                load_i,
    input  logic                hold_i,
    input  logic                flush_i,
    input  logic [LEN_INST-1:0] inst_i,
    input  logic [31:0]         pc4_i,
    output logic [LEN_INST-1:0] inst_o,
    output logic [31:0]         pc4_o,
    output logic                valid_o
);

    logic [LEN_INST-1:0] inst_q;
    logic [31:0]         pc4_q;
    logic                valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i && !hold_i) begin
            inst_q  <= inst_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request/hold/drop FSM with a one-entry skid buffer.
// Define DELAY_SLOT_EN to keep the IF/ID contents on a redirect (branch delay slot).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0]         RESET_PC = 32'h0000_0000,
    parameter logic [LEN_INST-1:0] NOP_INST = NOP_ENC
) (
    input  logic                clk,
    input  logic                rst,
    output logic [31:0]         imem_addr,
    output logic                imem_req,
    input  logic [LEN_INST-1:0] imem_rdata,
    input  logic                imem_ready,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [LEN_INST-1:0] id_inst,
    output logic [31:0]         id_pc4,
    output logic                id_valid
);

`ifdef DELAY_SLOT_EN
    localparam logic FLUSH_ON_REDIRECT = 1'b0;
`else
    localparam logic FLUSH_ON_REDIRECT = 1'b1;
`endif

    fetch_state_e        state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [LEN_INST-1:0] buf_q, buf_d;
    logic                ld, fl;
    logic [LEN_INST-1:0] ld_inst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        ld      = 1'b0;
        fl      = 1'b0;
        ld_inst = imem_rdata;
        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    buf_d   = '0;
                    fl      = FLUSH_ON_REDIRECT;
                    state_d = imem_ready ? ST_REQ : ST_DROP;
                end else if (imem_ready) begin
                    if (!stall) begin
                        ld   = 1'b1;
                        pc_d = pc_plus4(pc_q);
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (!stall) begin
                    fl = 1'b1;  // bubble while the memory is busy
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    buf_d   = '0;
                    fl      = FLUSH_ON_REDIRECT;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    ld      = 1'b1;
                    ld_inst = buf_q;
                    pc_d    = pc_plus4(pc_q);
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                // The stale response still has to arrive before a new request may issue.
                if (redirect) begin
                    pc_d    = word_align(redirect_pc);
                    fl      = FLUSH_ON_REDIRECT;
                    state_d = imem_ready ? ST_REQ : ST_DROP;
                end else if (imem_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk_i   (clk),
        .rst_n_i (rst),
        .load_i  (ld),
        .hold_i  (stall && !redirect),
        .flush_i (fl),
        .inst_i  (ld_inst),
        .pc4_i   (pc_plus4(pc_q)),
        .inst_o  (id_inst),
        .pc4_o   (id_pc4),
        .valid_o (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID loads are queued by the stimulus
// and popped by a monitor; control outputs are checked directly.
module tb_fetch_stage;

    logic        clk;
    logic        rst, rst2;
    logic        rdy, rdy2;
    logic        stall, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] imem_addr, imem_rdata, id_inst, id_pc4;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr2, imem_rdata2, id_inst2, id_pc4_2;
    logic        imem_req2, id_valid2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Memory model: each word holds C0DE in the top half and its address in the bottom.
    assign imem_rdata  = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};
    assign imem_rdata2 = 32'hC0DE_0000 | {16'h0, imem_addr2[15:0]};

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(rdy), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) dut_wrap (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_req(imem_req2),
        .imem_rdata(imem_rdata2), .imem_ready(rdy2), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'h0),
        .id_inst(id_inst2), .id_pc4(id_pc4_2), .id_valid(id_valid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
        exp_t e;
        e.inst = inst;
        e.pc4  = pc4;
        q.push_back(e);
    endtask

    // Monitor: a valid IF/ID after an unstalled edge is a fresh load.
    initial begin
        logic st, rs;
        exp_t e;
        forever begin
            @(posedge clk);
            st = stall;
            rs = rst;
            #1;
            if (rs && !st && id_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_load: got inst %h pc4 %h with empty queue", id_inst, id_pc4);
                end else begin
                    e = q.pop_front();
                    chk("sb_inst", id_inst, e.inst);
                    chk("sb_pc4", id_pc4, e.pc4);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; rst2 = 1'b0; rdy = 1'b0; rdy2 = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        cyc(); cyc();
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst2_inst", id_inst2, 32'h0000_0013);
        chk("rst2_addr", imem_addr2, 32'hFFFF_FFFC);

        // Streaming with memory always ready
        rst = 1'b1; rdy = 1'b1;
        push(32'hC0DE_0000, 32'd4);
        cyc();
        chk("seq_addr4", imem_addr, 32'd4);
        push(32'hC0DE_0004, 32'd8);
        cyc();
        chk("seq_addr8", imem_addr, 32'd8);

        // Stall while the response arrives: skid into HOLD for three cycles
        stall = 1'b1;
        push(32'hC0DE_0008, 32'd12);
        cyc();
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        chk("hold_pc4", id_pc4, 32'd8);
        chk("hold_inst", id_inst, 32'hC0DE_0004);
        cyc(); cyc();
        chk("hold_req3", {31'h0, imem_req}, 32'h0);
        stall = 1'b0; rdy = 1'b0;
        cyc();
        chk("rel_addr", imem_addr, 32'd12);
        chk("rel_req", {31'h0, imem_req}, 32'h1);

        // Redirect with the request still outstanding
        redirect = 1'b1; redirect_pc = 32'h43;
        cyc();
        chk("drop_valid", {31'h0, id_valid}, 32'h0);
        chk("drop_req", {31'h0, imem_req}, 32'h0);
        redirect = 1'b0;
        cyc();
        chk("drop_wait_req", {31'h0, imem_req}, 32'h0);
        rdy = 1'b1;
        cyc();
        chk("drop_done_valid", {31'h0, id_valid}, 32'h0);
        chk("drop_done_addr", imem_addr, 32'h40);
        chk("drop_done_req", {31'h0, imem_req}, 32'h1);
        push(32'hC0DE_0040, 32'h44);
        cyc();
        chk("after_drop_addr", imem_addr, 32'h44);

        // Redirect and stall together in HOLD: redirect wins
        stall = 1'b1;
        cyc();
        chk("hold2_req", {31'h0, imem_req}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100;
        cyc();
        chk("rw_addr", imem_addr, 32'h100);
        chk("rw_req", {31'h0, imem_req}, 32'h1);
        chk("rw_valid", {31'h0, id_valid}, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        push(32'hC0DE_0100, 32'h104);
        cyc();
        chk("rw_next_addr", imem_addr, 32'h104);

        // Memory busy without stall: bubble
        rdy = 1'b0;
        cyc();
        chk("bubble_valid", {31'h0, id_valid}, 32'h0);
        chk("bubble_addr", imem_addr, 32'h104);

        // Reset with a fetch outstanding
        rst = 1'b0;
        cyc();
        chk("mid_rst_valid", {31'h0, id_valid}, 32'h0);
        chk("mid_rst_inst", id_inst, 32'h0);
        chk("mid_rst_pc4", id_pc4, 32'h0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h1);
        chk("mid_rst_addr", imem_addr, 32'h0);
        rst = 1'b1; rdy = 1'b1;
        push(32'hC0DE_0000, 32'd4);
        cyc();
        chk("restart_addr", imem_addr, 32'd4);
        rdy = 1'b0;

        // PC wrap from the top of the address space
        rst2 = 1'b1;
        cyc();
        chk("wrap_pc4", id_pc4_2, 32'h0);
        chk("wrap_addr", imem_addr2, 32'h0);
        chk("wrap_inst", id_inst2, 32'hC0DE_FFFC);
        chk("wrap_valid", {31'h0, id_valid2}, 32'h1);

        cyc(); cyc();
        chk("sb_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000: instruction driven on id_inst when the IF/ID register is flushed.
REQ-003 SHALL have one clock and synchronous, active-low reset. Ports: clk  in  1  clock (rising edge); rst  in  1  synchronous active-low reset.
REQ-004 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-005 SHALL have port imem_req  out  1  fetch request.
REQ-006 SHALL have port imem_rdata  in  `LEN_INST  returned instruction.
REQ-007 SHALL have port imem_ready  in  1  imem_rdata valid this cycle; completes the outstanding request.
REQ-008 SHALL have port stall  in  1  hazard hold; freeze PC and IF/ID.
REQ-009 SHALL have port redirect  in  1  taken branch/jump (PCSrc).
REQ-010 SHALL have port redirect_pc  in  32  branch/jump target.
REQ-011 SHALL have ports id_inst  out  `LEN_INST, id_pc4  out  32, and id_valid  out  1, forming the IF/ID register outputs.

Function
REQ-012 SHALL implement FSM states REQ, HOLD, DROP.
REQ-013 In REQ: imem_req=1 and imem_addr=pc.
REQ-014 In HOLD and DROP: imem_req=0.
REQ-015 REQ with imem_ready, !stall, !redirect: IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4; stay in REQ.
REQ-016 REQ with imem_ready, stall, !redirect: skid buffer <= imem_rdata; pc and IF/ID held; go to HOLD.
REQ-017 REQ with !imem_ready: if !stall, id_valid <= 0 (bubble); if stall, hold IF/ID.
REQ-018 HOLD with !stall: IF/ID <= {buffer, pc+4, 1}; pc <= pc+4; go to REQ.
REQ-019 HOLD with stall: hold everything.
REQ-020 Redirect priority: redirect SHALL override stall in every state.
REQ-021 Redirect handling: pc <= {redirect_pc[31:2], 2'b00}; IF/ID flushed per REQ-030; buffer discarded.
REQ-022 Next state after redirect: DROP if a request is outstanding without imem_ready this cycle; otherwise REQ.
REQ-023 DROP: wait for imem_ready, discard imem_rdata, then go to REQ; a further redirect in DROP updates pc and stays in DROP.
REQ-024 PC arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 Handshake: at most one request outstanding; imem_addr is stable from request until imem_ready.

Reset
REQ-026 rst=0 at a clock edge SHALL give pc=RESET_PC, state=REQ, id_valid=0, id_inst=NOP_INST, id_pc4=0, buffer cleared.
REQ-027 Outputs after reset: imem_req=1 and imem_addr=RESET_PC from the first cycle after rst rises.
REQ-028 Reset mid-operation: an outstanding fetch SHALL be abandoned without a DROP; the memory is reset by the same rst.

Configuration
REQ-029 Macro: feature controlled by DELAY_SLOT_EN.
REQ-030 DELAY_SLOT_EN undefined: redirect sets id_valid=0 and id_inst=NOP_INST.
REQ-031 DELAY_SLOT_EN defined: redirect preserves the current IF/ID contents (delay-slot instruction proceeds); only the in-flight or buffered fetch is discarded.

Structure
REQ-032 defs.v SHALL hold LEN_INST, the FSM state encodings, and the default NOP encoding.
REQ-033 Sub-module if_id_reg SHALL implement the IF/ID register (load, hold, flush inputs); the FSM and PC stay in fetch_stage.

Verification
REQ-034 Reset then imem_ready=1 every cycle -> imem_addr 0,4,8,...; id_pc4 4,8,12; id_valid=1 from cycle 2.
REQ-035 imem_ready=1 with stall=1 for 3 cycles at pc=8 -> state HOLD, imem_req=0, IF/ID unchanged; on stall release, id_inst = word at 8, id_pc4=12, next imem_addr=12.
REQ-036 redirect=1, redirect_pc=32'h43 while imem_ready=0 -> DROP; the next imem_ready data is discarded; then imem_addr=32'h40; id_valid=0 (macro off) or held (macro on).
REQ-037 redirect and stall asserted together in HOLD -> redirect wins: pc=redirect_pc, buffer dropped, state REQ.
REQ-038 RESET_PC=32'hFFFF_FFFC, ready always -> id_pc4=0, next imem_addr=0.
REQ-039 rst=0 during an outstanding request -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
